sync_fifo_ctrl: RTL and testbench
=================================

SYNC_FIFO_CTRL -- requirements
Module: sync_fifo_ctrl

Interface
REQ-001 SHALL have parameter DATA, default 16, meaning data word width in bits.
REQ-002 SHALL have parameter ADDR, default 5, meaning RAM address width; FIFO depth = 2^ADDR words.
REQ-003 SHALL have port clK  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port wr_EN  input  1  write request.
REQ-006 SHALL have port wr_DATA  input  DATA  write data.
REQ-007 SHALL have port rd_EN  input  1  read request.
REQ-008 SHALL have port rd_DATA  output  DATA  read data, valid when rd_VALID=1.
REQ-009 SHALL have port rd_VALID  output  1  registered read-data strobe.
REQ-010 SHALL have port full  output  1  count = 2^ADDR.
REQ-011 SHALL have port empty  output  1  count = 0.
REQ-012 SHALL have port count  output  ADDR+1  current occupancy.
REQ-013 SHALL have port ram_a_WR  output  1  dual-port RAM port-A write strobe.
REQ-014 SHALL have port ram_a_ADDR  output  ADDR  port-A address (write pointer).
REQ-015 SHALL have port ram_a_DIN  output  DATA  port-A write data.
REQ-016 SHALL have port ram_b_WR  output  1  port-B write strobe, constant 0.
REQ-017 SHALL have port ram_b_ADDR  output  ADDR  port-B address (read pointer).
REQ-018 SHALL have port ram_b_DOUT  input  DATA  port-B registered read data (1-cycle RAM latency).

Function
REQ-019 Write accepted iff wr_EN=1 and full=0 at the clock edge; full/empty/count are sampled pre-edge.
REQ-020 Read accepted iff rd_EN=1 and empty=0 at the clock edge.
REQ-021 Accepted write: ram_a_WR=wr_EN&~full combinationally, ram_a_ADDR=wptr, ram_a_DIN=wr_DATA; wptr increments by 1 modulo 2^ADDR.
REQ-022 ram_b_ADDR=rptr combinationally; accepted read increments rptr by 1 modulo 2^ADDR.
REQ-023 rd_VALID SHALL assert exactly one cycle after each accepted read; rd_DATA=ram_b_DOUT in that cycle.
REQ-024 count: +1 on write only, -1 on read only, unchanged when both or neither are accepted.
REQ-025 Full with simultaneous wr_EN and rd_EN: read accepted, write rejected, count becomes 2^ADDR-1.
REQ-026 Empty with simultaneous wr_EN and rd_EN: write accepted, read rejected, count becomes 1; no fall-through.
REQ-027 Pointer wrap: after address 2^ADDR-1 the next address SHALL be 0 with no gap or stall.
REQ-028 Rejected requests SHALL change no state except the error flags (REQ-034).
REQ-029 full and empty SHALL be registered decodes of the next count value, never both 1.

Reset
REQ-030 rst_n=0 SHALL asynchronously clear wptr, rptr and count, set empty=1, full=0 and rd_VALID=0, and clear the error flags.
REQ-031 Reset asserted mid-operation SHALL discard all contents and suppress any pending rd_VALID; RAM contents are don't-care.
REQ-032 After rst_n deasserts, the first rising edge SHALL already accept requests.

Configuration
REQ-033 Macro FIFO_ERR_FLAGS_EN, when defined, SHALL add outputs ovf_ERR (1) and udf_ERR (1).
REQ-034 With the macro defined: ovf_ERR sets sticky on wr_EN&full and udf_ERR sets sticky on rd_EN&empty; both clear only on reset. Without it: the ports and logic are absent and the remaining behaviour is identical.

Verification
REQ-035 Reset then idle -> empty=1, full=0, count=0, rd_VALID=0, ram_a_WR=0.
REQ-036 Write 0x0001..0x0020 (DATA=16, ADDR=5), then a 33rd write 0xDEAD -> full=1 after the 32nd, count=32, 33rd rejected with ram_a_WR=0; ovf_ERR=1 if enabled.
REQ-037 Drain all 32 -> rd_DATA=0x0001..0x0020 in order, each one cycle after its rd_EN; empty=1; one extra read gives no rd_VALID; udf_ERR=1 if enabled.
REQ-038 Sustained simultaneous write/read for 100 cycles at count=3 -> count stays 3, in-order data, pointers wrap past 31->0.
REQ-039 At full and at empty, simultaneous wr_EN=rd_EN=1 -> count becomes 31 and 1 respectively, per REQ-025/026.
REQ-040 Assert rst_n=0 asynchronously between edges while count=10 with a read in flight -> outputs immediately go to reset values; no rd_VALID follows.

Source files
------------

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: synchronous FIFO controller driving an external dual-port RAM.
// Optional feature macro: FIFO_ERR_FLAGS_EN adds sticky ovf_ERR/udf_ERR outputs.
// Ports:
//   clK, rst_n                  clock, async active-low reset
//   wr_EN, wr_DATA              write request and data
//   rd_EN                       read request
//   rd_DATA, rd_VALID           read data and its strobe, one cycle after the read
//   full, empty, count          registered occupancy status
//   ram_a_WR/ADDR/DIN           RAM port A (write side, address = write pointer)
//   ram_b_WR/ADDR, ram_b_DOUT   RAM port B (read side, address = read pointer, 1-cycle latency)
//   ovf_ERR, udf_ERR            sticky overflow/underflow flags (FIFO_ERR_FLAGS_EN only)
module sync_fifo_ctrl #(
   parameter int DATA = 16,
   parameter int ADDR = 5
) (
   input  logic            clK,
   input  logic            rst_n,
   input  logic            wr_EN,
   input  logic [DATA-1:0] wr_DATA,
   input  logic            rd_EN,
   output logic [DATA-1:0] rd_DATA,
   output logic            rd_VALID,
   output logic            full,
   output logic            empty,
   output logic [ADDR:0]   count,
   output logic            ram_a_WR,
   output logic [ADDR-1:0] ram_a_ADDR,
   output logic [DATA-1:0] ram_a_DIN,
   output logic            ram_b_WR,
   output logic [ADDR-1:0] ram_b_ADDR,
   input  logic [DATA-1:0] ram_b_DOUT
`ifdef FIFO_ERR_FLAGS_EN
   ,
   output logic            ovf_ERR,
   output logic            udf_ERR
`endif
);
   localparam int DEPTH = 1 << ADDR;
   logic [ADDR-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [ADDR:0]   count_q, count_d;
   logic            full_q, empty_q, rd_valid_q;
   logic            wr_acc, rd_acc;
   // Full blocks the write and empty blocks the read, so a simultaneous request
   // at either extreme degenerates into a single accepted operation.
   assign wr_acc  = wr_EN & ~full_q;
   assign rd_acc  = rd_EN & ~empty_q;
   assign wptr_d  = wptr_q + ADDR'(wr_acc);
   assign rptr_d  = rptr_q + ADDR'(rd_acc);
   assign count_d = count_q + (ADDR+1)'(wr_acc) - (ADDR+1)'(rd_acc);
   always_ff @(posedge clK or negedge rst_n)
      if (!rst_n) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         rd_valid_q <= 1'b0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         full_q     <= count_d == (ADDR+1)'(DEPTH);
         empty_q    <= count_d == '0;
         rd_valid_q <= rd_acc;
      end
   assign ram_a_WR   = wr_acc;
   assign ram_a_ADDR = wptr_q;
   assign ram_a_DIN  = wr_DATA;
   assign ram_b_WR   = 1'b0;
   assign ram_b_ADDR = rptr_q;
   // The RAM registers its output on the same edge that accepts the read, so the
   // data is already aligned with rd_VALID and passes straight through.
   assign rd_DATA  = ram_b_DOUT;
   assign rd_VALID = rd_valid_q;
   assign full     = full_q;
   assign empty    = empty_q;
   assign count    = count_q;
`ifdef FIFO_ERR_FLAGS_EN
   logic ovf_q, udf_q;
   always_ff @(posedge clK or negedge rst_n)
      if (!rst_n) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_q | (wr_EN & full_q);
         udf_q <= udf_q | (rd_EN & empty_q);
      end
   assign ovf_ERR = ovf_q;
   assign udf_ERR = udf_q;
`endif
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb_sync_fifo_ctrl: directed self-checking bench for sync_fifo_ctrl with a behavioural dual-port RAM.
module tb_sync_fifo_ctrl;
   logic        clk = 1'b0;
   logic        rst_n, wr_en, rd_en;
   logic [15:0] wr_data, rd_data, a_din, b_dout;
   logic        rd_valid, full, empty, a_wr, b_wr;
   logic [5:0]  count;
   logic [4:0]  a_addr, b_addr;
`ifdef FIFO_ERR_FLAGS_EN
   logic        ovf, udf;
`endif
   int          n_vec = 0, n_err = 0;
   logic [15:0] mem [32];

   sync_fifo_ctrl #(.DATA(16), .ADDR(5)) dut (
      .clK(clk), .rst_n(rst_n), .wr_EN(wr_en), .wr_DATA(wr_data), .rd_EN(rd_en),
      .rd_DATA(rd_data), .rd_VALID(rd_valid), .full(full), .empty(empty), .count(count),
      .ram_a_WR(a_wr), .ram_a_ADDR(a_addr), .ram_a_DIN(a_din),
      .ram_b_WR(b_wr), .ram_b_ADDR(b_addr), .ram_b_DOUT(b_dout)
`ifdef FIFO_ERR_FLAGS_EN
      , .ovf_ERR(ovf), .udf_ERR(udf)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (a_wr) mem[a_addr] <= a_din;
      b_dout <= mem[b_addr];
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
      repeat (2) tick;
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_count", count, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_a_wr", a_wr, 0);
      chk("b_wr_const", b_wr, 0);
`ifdef FIFO_ERR_FLAGS_EN
      chk("rst_ovf", ovf, 0);
      chk("rst_udf", udf, 0);
`endif
      rst_n = 1'b1;
      wr_en = 1'b1;
      for (int i = 1; i <= 32; i++) begin
         wr_data = 16'(i);
         #1;
         chk("fill_a_wr", a_wr, 1);
         chk("fill_a_addr", a_addr, 32'(i - 1));
         chk("fill_a_din", a_din, 32'(i));
         tick;
         chk("fill_count", count, 32'(i));
         chk("fill_full", full, (i == 32) ? 1 : 0);
         chk("fill_empty", empty, 0);
      end
      wr_data = 16'hDEAD;
      #1;
      chk("ovf_a_wr", a_wr, 0);
      tick;
      chk("ovf_count", count, 32);
      chk("ovf_full", full, 1);
      chk("ovf_wptr_held", a_addr, 0);
`ifdef FIFO_ERR_FLAGS_EN
      chk("ovf_flag", ovf, 1);
      chk("ovf_no_udf", udf, 0);
`endif
      wr_en = 1'b0;
      rd_en = 1'b1;
      for (int k = 1; k <= 32; k++) begin
         #1;
         chk("drain_b_addr", b_addr, 32'(k - 1));
         tick;
         chk("drain_rd_valid", rd_valid, 1);
         chk("drain_rd_data", rd_data, 32'(k));
         chk("drain_count", count, 32'(32 - k));
      end
      chk("drain_empty", empty, 1);
      chk("drain_full", full, 0);
      tick;
      chk("udf_rd_valid", rd_valid, 0);
      chk("udf_count", count, 0);
      chk("udf_rptr_held", b_addr, 0);
`ifdef FIFO_ERR_FLAGS_EN
      chk("udf_flag", udf, 1);
`endif
      wr_en = 1'b1;
      wr_data = 16'h0100;
      tick;
      chk("both_empty_count", count, 1);
      chk("both_empty_no_fallthru", rd_valid, 0);
      chk("both_empty_empty", empty, 0);
      rd_en = 1'b0;
      wr_data = 16'h0101;
      tick;
      wr_data = 16'h0102;
      tick;
      chk("pre_stream_count", count, 3);
      rd_en = 1'b1;
      for (int i = 0; i < 100; i++) begin
         wr_data = 16'(16'h0103 + i);
         #1;
         chk("stream_b_addr", b_addr, 32'(i % 32));
         tick;
         chk("stream_rd_valid", rd_valid, 1);
         chk("stream_rd_data", rd_data, 32'(16'h0100 + i));
         chk("stream_count", count, 3);
      end
      rd_en = 1'b0;
      for (int j = 0; j < 29; j++) begin
         wr_data = 16'(16'h0200 + j);
         tick;
      end
      chk("refill_count", count, 32);
      chk("refill_full", full, 1);
      rd_en = 1'b1;
      wr_data = 16'hBEEF;
      #1;
      chk("both_full_a_wr", a_wr, 0);
      tick;
      chk("both_full_count", count, 31);
      chk("both_full_full", full, 0);
      chk("both_full_rd_valid", rd_valid, 1);
      chk("both_full_rd_data", rd_data, 32'h0164);
      wr_en = 1'b0;
      repeat (21) tick;
      chk("pre_rst_count", count, 10);
      chk("pre_rst_rd_valid", rd_valid, 1);
      chk("pre_rst_rd_data", rd_data, 32'h0212);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_count", count, 0);
      chk("async_rst_empty", empty, 1);
      chk("async_rst_full", full, 0);
      chk("async_rst_rd_valid", rd_valid, 0);
      chk("async_rst_b_addr", b_addr, 0);
      chk("async_rst_a_addr", a_addr, 0);
`ifdef FIFO_ERR_FLAGS_EN
      chk("async_rst_ovf", ovf, 0);
      chk("async_rst_udf", udf, 0);
`endif
      rd_en = 1'b0;
      @(posedge clk);
      #2;
      chk("held_rst_rd_valid", rd_valid, 0);
      rst_n = 1'b1;
      wr_en = 1'b1;
      wr_data = 16'h55AA;
      tick;
      chk("first_edge_count", count, 1);
      chk("first_edge_rd_valid", rd_valid, 0);
      wr_en = 1'b0;
      rd_en = 1'b1;
      tick;
      chk("post_rst_rd_valid", rd_valid, 1);
      chk("post_rst_rd_data", rd_data, 32'h55AA);
      chk("post_rst_empty", empty, 1);
      rd_en = 1'b0;
      tick;
      chk("post_rst_idle_valid", rd_valid, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
